// File: rtl/shift_seq_if.sv
// shift_seq_if: request/response bundle for shift_seq plus its serial link
// to the attached shift register (ser_out/shift_ena out, qin back).
interface shift_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic             qin;
    logic             ser_out;
    logic             shift_ena;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] rx_data;
    logic             match;
    logic             parity_err;
    modport master (
        output start, tx_data, qin,
        input  ser_out, shift_ena, ready, done, rx_data, match, parity_err
    );
    modport slave (
        input  start, tx_data, qin,
        output ser_out, shift_ena, ready, done, rx_data, match, parity_err
    );
endinterface

// File: rtl/shift_seq.sv
// shift_seq: pushes a WIDTH-bit frame through an external DEPTH-stage shift register
// and recovers it from qin; SHIFT_PARITY_EN appends and checks an even-parity bit.
module shift_seq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    shift_seq_if.slave bus
);
`ifdef SHIFT_PARITY_EN
    localparam int F = WIDTH + 1;
`else
    localparam int F = WIDTH;
`endif
    localparam int N  = F + DEPTH;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0]    cnt;
    logic [F-1:0]     frame, frame_in, rx_nx;
    logic [F-2:0]     rx_sh;
    logic [WIDTH-1:0] tx_q;
    logic             last;

    assign last  = cnt == CW'(N - 1);
    assign rx_nx = {rx_sh, bus.qin};

`ifdef SHIFT_PARITY_EN
    assign frame_in = {bus.tx_data, ^bus.tx_data};
    // received parity bit xor parity of rx_data collapses to parity of the whole frame
    always_ff @(posedge clk) begin
        if (!rst)
            bus.parity_err <= 1'b0;
        else if (state == SHIFT && last)
            bus.parity_err <= ^rx_nx;
    end
`else
    assign frame_in       = bus.tx_data;
    assign bus.parity_err = 1'b0;
`endif

    always_comb begin
        state_nx      = state;
        bus.ready     = state == IDLE;
        bus.shift_ena = state == SHIFT;
        bus.done      = state == DONE;
        bus.ser_out   = (state == SHIFT) & frame[F-1];
        if (state == IDLE && bus.start)
            state_nx = SHIFT;
        else if (state == SHIFT && last)
            state_nx = DONE;
        else if (state == DONE)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == SHIFT && !last) ? cnt + 1'b1 : '0;
        end
    end

    // frame shifts left each SHIFT cycle, so zeros follow the last frame bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame       <= '0;
            rx_sh       <= '0;
            tx_q        <= '0;
            bus.rx_data <= '0;
            bus.match   <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            frame <= frame_in;
            tx_q  <= bus.tx_data;
        end else if (state == SHIFT) begin
            frame <= frame << 1;
            if (cnt >= CW'(DEPTH))
                rx_sh <= rx_nx[F-2:0];
            if (last) begin
                bus.rx_data <= rx_nx[F-1 -: WIDTH];
                bus.match   <= rx_nx[F-1 -: WIDTH] == tx_q;
            end
        end
    end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: random and directed transfers through an ideal DEPTH-stage register,
// checked against a frame-level model of what should come back.
module tb_shift_seq;
    localparam int W = 8;
    localparam int D = 4;
`ifdef SHIFT_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif
    localparam int N = F + D;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [D-1:0] sr = '0;
    logic         force_one = 1'b0;
    logic         flip_now = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    shift_seq_if #(.WIDTH(W)) bus ();
    shift_seq #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.shift_ena) sr <= {sr[D-2:0], bus.ser_out};

    assign bus.qin = force_one | (sr[D-1] ^ flip_now);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [F-1:0] frame_of(input logic [W-1:0] tx);
`ifdef SHIFT_PARITY_EN
        return {tx, ^tx};
`else
        return tx;
`endif
    endfunction

    // mode 0: ideal register, 1: received frame bit fj inverted, 2: qin stuck at 1
    task automatic xfer(input logic [W-1:0] tx, input int mode, input int fj, input bit busy);
        logic [F-1:0] fr, rf, sent;
        logic [W-1:0] er;
        int en, done_at, dones;
        bit tail_ok;
        en = 0; done_at = -1; dones = 0; tail_ok = 1; sent = '0;
        fr = frame_of(tx);
        rf = mode == 2 ? '1 : mode == 1 ? fr ^ (F'(1) << (F - 1 - fj)) : fr;
        er = rf[F-1 -: W];
        bus.start = 1'b1;
        bus.tx_data = tx;
        force_one = mode == 2;
        @(negedge clk);
        bus.start = 1'b0;
        bus.tx_data = W'($urandom);
        for (int c = 1; c <= N + 4; c++) begin
            flip_now = mode == 1 && c - 1 == D + fj;
            if (busy && c == 3) begin
                bus.start = 1'b1;
                bus.tx_data = W'(8'h3C);
            end
            if (busy && c == 4) bus.start = 1'b0;
            if (bus.shift_ena) begin
                en++;
                if (c - 1 < F) sent[F-c] = bus.ser_out;
                else if (bus.ser_out) tail_ok = 0;
            end
            if (bus.done) begin
                dones++;
                done_at = c;
                check("rx_data", 32'(bus.rx_data), 32'(er));
                check("match", 32'(bus.match), 32'(er == tx));
`ifdef SHIFT_PARITY_EN
                check("parity_err", 32'(bus.parity_err), 32'(^rf));
`else
                check("parity_err", 32'(bus.parity_err), 32'(0));
`endif
            end
            if (done_at > 0 && c == done_at + 1) check("ready_after_done", 32'(bus.ready), 32'(1));
            @(negedge clk);
        end
        force_one = 1'b0;
        flip_now = 1'b0;
        check("shift_ena_cycles", 32'(en), 32'(N));
        check("done_latency", 32'(done_at), 32'(N + 1));
        check("done_count", 32'(dones), 32'(1));
        check("ser_frame", 32'(sent), 32'(fr));
        check("ser_tail_zero", 32'(tail_ok), 32'(1));
    endtask

    task automatic abort_mid_shift();
        int dones;
        dones = 0;
        bus.start = 1'b1;
        bus.tx_data = W'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_shift_ena", 32'(bus.shift_ena), 32'(0));
        check("abort_ready", 32'(bus.ready), 32'(1));
        check("abort_rx_data", 32'(bus.rx_data), 32'(0));
        check("abort_match", 32'(bus.match), 32'(0));
        for (int c = 0; c < N + 4; c++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(dones), 32'(0));
    endtask

    task automatic back_to_back();
        int times[$];
        logic [W-1:0] tx;
        tx = W'($urandom);
        bus.start = 1'b1;
        bus.tx_data = tx;
        for (int c = 1; c <= 4 * (N + 2) + 4 && times.size() < 3; c++) begin
            @(negedge clk);
            if (bus.done) begin
                times.push_back(c);
                check("b2b_rx_data", 32'(bus.rx_data), 32'(tx));
                if (times.size() == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("b2b_done_count", 32'(times.size()), 32'(3));
        if (times.size() == 3) begin
            check("b2b_gap1", 32'(times[1] - times[0]), 32'(N + 2));
            check("b2b_gap2", 32'(times[2] - times[1]), 32'(N + 2));
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b1;
        bus.tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'(1));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_shift_ena", 32'(bus.shift_ena), 32'(0));
        check("rst_ser_out", 32'(bus.ser_out), 32'(0));
        check("rst_rx_data", 32'(bus.rx_data), 32'(0));
        check("rst_match", 32'(bus.match), 32'(0));
        check("rst_parity_err", 32'(bus.parity_err), 32'(0));
        rst = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        xfer(W'(8'hA5), 0, 0, 0);
        xfer(W'(8'hA5), 2, 0, 0);
        xfer(W'(8'hA5), 0, 0, 1);
        abort_mid_shift();
`ifdef SHIFT_PARITY_EN
        xfer(W'(8'h07), 0, 0, 0);
        xfer(W'(8'h07), 1, 3, 0);
        xfer(W'(8'h07), 1, W, 0);
`endif
        for (int i = 0; i < 12; i++)
            xfer(W'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, F - 1)), bit'($urandom_range(0, 1)));
        back_to_back();
        xfer(W'(8'h00), 0, 0, 0);
        xfer(W'(8'hFF), 1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
